// File: rtl/psum_accumulator.sv
// Dot-product partial-sum accumulator with Q1.7 requantized output.
// Define PSUM_ACC_SAT_EN for a saturating accumulator with a sticky acc_ovf flag.
module psum_accumulator #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_product,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_psum,
  output logic [7:0]           out_q,
  output logic                 out_sat,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 acc_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t               state;
  logic [31:0]          acc;
  logic [CNT_WIDTH-1:0] cnt;

  logic                 take;
  logic                 done;
  logic [31:0]          acc_nxt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic signed [32:0]   rnd;
  logic                 hi_clip;
  logic                 lo_clip;
  logic [7:0]           q_nxt;
  logic                 unused_rnd;

  // rst_n is active-high here, so the port is blocked while it is 1
  assign in_ready = (state != HOLD) && !rst_n;
  assign take     = in_valid && in_ready;
  assign done     = out_valid && out_ready;

`ifdef PSUM_ACC_SAT_EN
  logic [32:0] sum;
  logic        add_ovf;
  logic        ovf_sticky;
  logic        ovf_nxt;
  logic        ovf_q;

  assign sum     = {acc[31], acc} + {in_product[31], in_product};
  assign add_ovf = sum[32] ^ sum[31];
  assign acc_ovf = ovf_q;
`else
  assign acc_ovf = 1'b0;
`endif

  always_comb begin
    acc_nxt = in_product;
    cnt_nxt = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
`ifdef PSUM_ACC_SAT_EN
    ovf_nxt = 1'b0;
`endif
    if (state == ACCUM) begin
      cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;
`ifdef PSUM_ACC_SAT_EN
      ovf_nxt = ovf_sticky | add_ovf;
      if (add_ovf)
        acc_nxt = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else
        acc_nxt = sum[31:0];
`else
      acc_nxt = acc + in_product;
`endif
    end
  end

  // r = rnd >>> 7, so clip thresholds are scaled by 128
  assign rnd     = $signed({acc_nxt[31], acc_nxt}) + 33'sd64;
  assign hi_clip = rnd > 33'sd16383;
  assign lo_clip = rnd < -33'sd16384;
  assign q_nxt   = hi_clip ? 8'h7F :
                   lo_clip ? 8'h80 : rnd[14:7];
  assign unused_rnd = ^rnd[6:0];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_psum  <= '0;
      out_q     <= '0;
      out_sat   <= 1'b0;
      out_count <= '0;
`ifdef PSUM_ACC_SAT_EN
      ovf_sticky <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (take) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
`ifdef PSUM_ACC_SAT_EN
            ovf_sticky <= ovf_nxt;
`endif
            if (in_last) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_psum  <= acc_nxt;
              out_q     <= q_nxt;
              out_sat   <= hi_clip | lo_clip;
              out_count <= cnt_nxt;
`ifdef PSUM_ACC_SAT_EN
              ovf_q     <= ovf_nxt;
`endif
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (done) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
`ifdef PSUM_ACC_SAT_EN
            ovf_sticky <= 1'b0;
            ovf_q      <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: scoreboard of expected results,
// second instance with a 2-bit counter exercises counter saturation.
module tb_psum_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_product;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_psum;
  logic [7:0]  out_q;
  logic        out_sat;
  logic [15:0] out_count;
  logic        acc_ovf;

  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_psum2;
  logic [7:0]  out_q2;
  logic        out_sat2;
  logic [1:0]  out_count2;
  logic        acc_ovf2;

  typedef struct {
    logic [31:0] psum;
    logic [7:0]  q;
    logic        sat;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] seq[$];
  int          errors = 0;
  int          checks = 0;

  psum_accumulator #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_product(in_product), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_psum(out_psum), .out_q(out_q), .out_sat(out_sat),
    .out_count(out_count), .acc_ovf(acc_ovf)
  );

  psum_accumulator #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_product(in_product), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_psum(out_psum2), .out_q(out_q2), .out_sat(out_sat2),
    .out_count(out_count2), .acc_ovf(acc_ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] p[$]);
    exp_t   e;
    longint a;
    longint r;
    bit     o;
    o = 1'b0;
    a = longint'($signed(p[0]));
    for (int i = 1; i < p.size(); i++) begin
      a = a + longint'($signed(p[i]));
`ifdef PSUM_ACC_SAT_EN
      if (a > 64'sd2147483647) begin
        a = 64'sd2147483647;
        o = 1'b1;
      end else if (a < -64'sd2147483648) begin
        a = -64'sd2147483648;
        o = 1'b1;
      end
`else
      a = longint'(int'(a[31:0]));
`endif
    end
    r = (a + 64) >>> 7;
    e.sat = 1'b1;
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
    else e.sat = 1'b0;
    e.psum = a[31:0];
    e.q    = r[7:0];
    e.ovf  = o;
    e.cnt  = (p.size() > 65535) ? 16'hFFFF : 16'(p.size());
    e.cnt2 = (p.size() > 3) ? 2'd3 : 2'(p.size());
    return e;
  endfunction

  task automatic send(input logic [31:0] p, input logic last);
    in_valid   = 1'b1;
    in_product = p;
    in_last    = last;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_in_ready got=%b exp=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic compare_out(input exp_t e, input string tag);
    checks++;
    if (out_psum !== e.psum || out_psum2 !== e.psum) begin
      errors++;
      $display("FAIL %s psum got=%h/%h exp=%h", tag, out_psum, out_psum2, e.psum);
    end
    checks++;
    if (out_q !== e.q || out_sat !== e.sat) begin
      errors++;
      $display("FAIL %s q/sat got=%h/%b exp=%h/%b", tag, out_q, out_sat, e.q, e.sat);
    end
    checks++;
    if (out_count !== e.cnt || out_count2 !== e.cnt2) begin
      errors++;
      $display("FAIL %s count got=%0d/%0d exp=%0d/%0d",
               tag, out_count, out_count2, e.cnt, e.cnt2);
    end
    checks++;
    if (acc_ovf !== e.ovf) begin
      errors++;
      $display("FAIL %s acc_ovf got=%b exp=%b", tag, acc_ovf, e.ovf);
    end
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout out_valid got=%b exp=1", tag, out_valid);
      if (sb.size() > 0) e = sb.pop_front();
      return;
    end
    e = sb.pop_front();
    compare_out(e, tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sat !== 1'b0 || acc_ovf !== 1'b0) begin
      errors++;
      $display("FAIL %s release got v=%b rdy=%b sat=%b ovf=%b exp 0/1/0/0",
               tag, out_valid, in_ready, out_sat, acc_ovf);
    end
  endtask

  task automatic run_seq(input logic [31:0] p[$], input string tag);
    sb.push_back(model(p));
    for (int i = 0; i < p.size(); i++)
      send(p[i], i == p.size() - 1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency out_valid got=%b exp=1", tag, out_valid);
    end
    collect(tag);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_product = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_psum !== 32'd0 ||
        out_q !== 8'd0 || out_sat !== 1'b0 || out_count !== 16'd0 || acc_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b v=%b psum=%h q=%h sat=%b cnt=%0d ovf=%b exp all 0",
               in_ready, out_valid, out_psum, out_q, out_sat, out_count, acc_ovf);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready got=%b exp=1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    seq = {32'd100, 32'd30};
    run_seq(seq, "scen1");
    seq = {32'h0000_4000, 32'h0000_4000, 32'h0000_4000};
    run_seq(seq, "scen2");
    seq = {-32'sd200};
    run_seq(seq, "scen3");
    seq = {32'd63};
    run_seq(seq, "round_down");
    seq = {32'd64};
    run_seq(seq, "round_half_up");
    seq = {-32'sd16448, 32'd0, 32'd0, 32'd0, 32'd0};
    run_seq(seq, "lo_edge_cnt_sat");
    seq = {-32'sd16449};
    run_seq(seq, "lo_clip");
  endtask

  task automatic test_backpressure;
    exp_t e;
    seq = {32'd500, -32'sd20};
    sb.push_back(model(seq));
    send(seq[0], 1'b0);
    send(seq[1], 1'b1);
    in_valid   = 1'b1;
    in_product = 32'd99;
    in_last    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_%0d rdy/v got=%b/%b exp=0/1", i, in_ready, out_valid);
      end
      compare_out(sb[0], "hold_stable");
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_exit v/rdy got=%b/%b exp=0/1", out_valid, in_ready);
    end
    seq = {32'd99};
    sb.push_back(model(seq));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL accept_after_hold out_valid got=%b exp=1", out_valid);
    end
    collect("after_hold");
  endtask

  task automatic test_reset_mid;
    send(32'd11, 1'b0);
    send(32'd22, 1'b0);
    send(32'd33, 1'b0);
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b v=%b cnt=%0d exp 0/0/0", in_ready, out_valid, out_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_%0d v/rdy got=%b/%b exp=0/1", i, out_valid, in_ready);
      end
      @(posedge clk); #1;
    end
    seq = {32'd5, 32'd7};
    run_seq(seq, "scen5");
  endtask

  task automatic test_overflow;
    seq = {32'h7FFF_F000, 32'h0000_2000};
    run_seq(seq, "scen6_pos");
    seq = {32'h8000_1000, 32'hFFFF_E000, 32'd5};
    run_seq(seq, "ovf_neg");
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 5);
      seq = {};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0)
          seq.push_back($urandom);
        else
          seq.push_back(32'($urandom_range(0, 40000)) - 32'd20000);
      end
      run_seq(seq, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_overflow();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
